mac_tx_fifo: RTL and testbench

Parametrised successor to the MAC TX line buffer: a first-word-fall-through FIFO of N_CH-lane XGMII-style words, each word being a per-lane control/valid bit plus one byte per lane, with an end-of-frame tag. It sits between the MAC TX framer (writer) and the TX encoder/scheduler (reader). Beyond plain buffering it adds:
- full and almost-full back-pressure,
- an occupancy level,
- a count of complete frames held,
- sticky overflow and underflow error flags.

---
 rtl/mac_params_pkg.sv | 17 +
 rtl/mac_tx_fifo_mem.sv | 27 ++
 rtl/mac_tx_fifo.sv | 120 ++++++++++++
 tb/tb_mac_tx_fifo.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_params_pkg.sv
// Shared MAC parameters and bus payload types.
// The MAC TX FIFO storage word is declared here.
package mac_params_pkg;

    localparam int unsigned MAC_N_CH          = 4;
    localparam int unsigned MAC_W_BYTE        = 8;
    localparam int unsigned N_MAC_TX_FIFO     = 16;
    localparam int unsigned W_MAC_TX_FIFO_CNT = $clog2(N_MAC_TX_FIFO);

    // One stored word: end-of-frame tag, per-lane control, lane data (lane 0 in LSBs)
    typedef struct packed {
        logic                                   eof;
        logic [MAC_N_CH-1:0]                    ctrl;
        logic [MAC_N_CH-1:0][MAC_W_BYTE-1:0]    data;
    } mac_tx_word_t;

endpackage

// File: rtl/mac_tx_fifo_mem.sv
// Storage array for the MAC TX FIFO: one clock-enabled write port, one async read port.
// Contents are intentionally not reset.
module mac_tx_fifo_mem #(
    parameter  int unsigned W_WORD = 37,
    parameter  int unsigned DEPTH  = 16,
    localparam int unsigned W_ADDR = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              clk_en,
    input  logic              wen,
    input  logic [W_ADDR-1:0] waddr,
    input  logic [W_WORD-1:0] wdata,
    input  logic [W_ADDR-1:0] raddr,
    output logic [W_WORD-1:0] rdata
);

    logic [W_WORD-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (clk_en && wen) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mac_tx_fifo.sv
// First-word-fall-through FIFO between the MAC TX framer and the TX encoder.
// Tracks level, complete frames held, and sticky overflow/underflow errors.
module mac_tx_fifo
    import mac_params_pkg::*;
#(
    parameter  int unsigned N_CH     = MAC_N_CH,
    parameter  int unsigned W_BYTE   = MAC_W_BYTE,
    parameter  int unsigned DEPTH    = N_MAC_TX_FIFO,
    parameter  int unsigned AFULL_TH = DEPTH - 4,
    localparam int unsigned W_CNT    = $clog2(DEPTH)
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_clk_en,
    input  logic                     i_clr,
    input  logic                     i_wen,
    input  logic [N_CH-1:0]          i_wctrl,
    input  logic [N_CH*W_BYTE-1:0]   i_wdata,
    input  logic                     i_weof,
    input  logic                     i_ren,
    output logic [N_CH-1:0]          o_rctrl,
    output logic [N_CH*W_BYTE-1:0]   o_rdata,
    output logic                     o_reof,
    output logic                     o_empty,
    output logic                     o_full,
    output logic                     o_afull,
    output logic [W_CNT:0]           o_level,
    output logic [W_CNT:0]           o_frames,
    output logic                     o_frame_avail,
    output logic                     o_overflow,
    output logic                     o_underflow
);

    localparam int unsigned W_WORD = $bits(mac_tx_word_t);

    logic [W_CNT:0] wptr;
    logic [W_CNT:0] rptr;
    logic [W_CNT:0] frames;
    logic           overflow;
    logic           underflow;

    logic           empty;
    logic           full;
    logic           wr_ok;
    logic           rd_ok;
    mac_tx_word_t   wword;
    mac_tx_word_t   head;
    logic [W_WORD-1:0] head_raw;

    // Flags come straight from the registered pointers; the extra MSB separates full from empty
    assign empty = (wptr == rptr);
    assign full  = (wptr[W_CNT-1:0] == rptr[W_CNT-1:0]) && (wptr[W_CNT] != rptr[W_CNT]);
    assign wr_ok = i_wen && !full;
    assign rd_ok = i_ren && !empty;

    always_comb begin
        wword      = '0;
        wword.eof  = i_weof;
        wword.ctrl = i_wctrl;
        wword.data = i_wdata;
    end

    mac_tx_fifo_mem #(
        .W_WORD (W_WORD),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk    (i_clk),
        .clk_en (i_clk_en && !i_clr),
        .wen    (wr_ok),
        .waddr  (wptr[W_CNT-1:0]),
        .wdata  (W_WORD'(wword)),
        .raddr  (rptr[W_CNT-1:0]),
        .rdata  (head_raw)
    );

    assign head = mac_tx_word_t'(head_raw);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wptr      <= '0;
            rptr      <= '0;
            frames    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (i_clk_en) begin
            if (i_clr) begin
                wptr      <= '0;
                rptr      <= '0;
                frames    <= '0;
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                if (wr_ok) begin
                    wptr <= wptr + (W_CNT+1)'(1);
                end
                if (rd_ok) begin
                    rptr <= rptr + (W_CNT+1)'(1);
                end
                // A frame leaves when its EOF word is popped
                frames    <= frames + (W_CNT+1)'(wr_ok && i_weof)
                                    - (W_CNT+1)'(rd_ok && head.eof);
                overflow  <= overflow  || (i_wen && full);
                underflow <= underflow || (i_ren && empty);
            end
        end
    end

    assign o_empty       = empty;
    assign o_full        = full;
    assign o_level       = wptr - rptr;
    assign o_afull       = (o_level >= (W_CNT+1)'(AFULL_TH));
    assign o_frames      = frames;
    assign o_frame_avail = (frames != '0);
    assign o_overflow    = overflow;
    assign o_underflow   = underflow;
    assign o_rctrl       = empty ? '0 : head.ctrl;
    assign o_reof        = empty ? 1'b0 : head.eof;
    assign o_rdata       = head.data;

endmodule

// File: tb/tb_mac_tx_fifo.sv
// Scoreboard bench for mac_tx_fifo: driver models the FIFO and queues expected pops,
// a negedge monitor compares the head word whenever a read handshake is presented.
module tb_mac_tx_fifo;

    typedef struct {
        logic        eof;
        logic [3:0]  ctrl;
        logic [31:0] data;
    } w_t;

    logic        clk;
    logic        rst_n;
    logic        clk_en;
    logic        clr;
    logic        wen;
    logic [3:0]  wctrl;
    logic [31:0] wdata;
    logic        weof;
    logic        ren;
    logic [3:0]  rctrl;
    logic [31:0] rdata;
    logic        reof;
    logic        empty;
    logic        full;
    logic        afull;
    logic [4:0]  level;
    logic [4:0]  frames;
    logic        frame_avail;
    logic        overflow;
    logic        underflow;

    int n_tests = 0;
    int n_fail  = 0;

    w_t mdl_q[$];
    w_t exp_q[$];
    int m_frames = 0;
    bit m_ovf = 0;
    bit m_unf = 0;

    mac_tx_fifo dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_clk_en      (clk_en),
        .i_clr         (clr),
        .i_wen         (wen),
        .i_wctrl       (wctrl),
        .i_wdata       (wdata),
        .i_weof        (weof),
        .i_ren         (ren),
        .o_rctrl       (rctrl),
        .o_rdata       (rdata),
        .o_reof        (reof),
        .o_empty       (empty),
        .o_full        (full),
        .o_afull       (afull),
        .o_level       (level),
        .o_frames      (frames),
        .o_frame_avail (frame_avail),
        .o_overflow    (overflow),
        .o_underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        int sz;
        sz = mdl_q.size();
        chk({tag, ".level"},  32'(level), 32'(sz));
        chk({tag, ".frames"}, 32'(frames), 32'(m_frames));
        chk({tag, ".favail"}, 32'(frame_avail), 32'(m_frames != 0));
        chk({tag, ".empty"},  32'(empty), 32'(sz == 0));
        chk({tag, ".full"},   32'(full), 32'(sz == 16));
        chk({tag, ".afull"},  32'(afull), 32'(sz >= 12));
        chk({tag, ".ovf"},    32'(overflow), 32'(m_ovf));
        chk({tag, ".unf"},    32'(underflow), 32'(m_unf));
        if (sz > 0) begin
            chk({tag, ".head_data"}, rdata, mdl_q[0].data);
            chk({tag, ".head_ctrl"}, 32'(rctrl), 32'(mdl_q[0].ctrl));
            chk({tag, ".head_eof"},  32'(reof), 32'(mdl_q[0].eof));
        end else begin
            chk({tag, ".empty_ctrl"}, 32'(rctrl), 32'd0);
            chk({tag, ".empty_eof"},  32'(reof), 32'd0);
        end
    endtask

    // One cycle of stimulus; model is updated from the pre-edge state
    task automatic step(input string tag, input bit w, input bit r,
                        input logic [3:0] c, input logic [31:0] d, input bit e,
                        input bit cl = 1'b0, input bit en = 1'b1);
        bit wok;
        bit rok;
        w_t hd;
        w_t nw;
        wen = w; ren = r; wctrl = c; wdata = d; weof = e; clr = cl; clk_en = en;
        if (en) begin
            if (cl) begin
                mdl_q.delete();
                m_frames = 0;
                m_ovf = 0;
                m_unf = 0;
            end else begin
                wok = w && (mdl_q.size() < 16);
                rok = r && (mdl_q.size() > 0);
                if (w && !wok) m_ovf = 1;
                if (r && !rok) m_unf = 1;
                if (rok) begin
                    hd = mdl_q.pop_front();
                    exp_q.push_back(hd);
                    if (hd.eof) m_frames--;
                end
                if (wok) begin
                    nw.eof = e; nw.ctrl = c; nw.data = d;
                    mdl_q.push_back(nw);
                    if (e) m_frames++;
                end
            end
        end
        @(posedge clk);
        #1;
        wen = 0; ren = 0; clr = 0; clk_en = 1; weof = 0;
        check_state(tag);
    endtask

    // Monitor: compare the presented head against the scoreboard on every read handshake
    always @(negedge clk) begin
        w_t x;
        if (rst_n && clk_en && ren && !clr) begin
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("mon.not_empty", 32'(empty), 32'd0);
                chk("mon.data", rdata, x.data);
                chk("mon.ctrl", 32'(rctrl), 32'(x.ctrl));
                chk("mon.eof",  32'(reof), 32'(x.eof));
            end else begin
                chk("mon.rd_on_empty", 32'(empty), 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 0; clk_en = 1; clr = 0; wen = 0; ren = 0;
        wctrl = '0; wdata = '0; weof = 0;
        #7;
        check_state("reset");
        #5 rst_n = 1;
        @(posedge clk);
        #1;

        // Three-word frame, then drain
        step("w1", 1, 0, 4'hF, 32'h11111111, 0);
        step("w2", 1, 0, 4'hF, 32'h22222222, 0);
        step("w3", 1, 0, 4'hF, 32'h33333333, 1);
        chk("basic.level3", 32'(level), 32'd3);
        chk("basic.head",   rdata, 32'h11111111);
        for (int i = 0; i < 3; i++) step("r", 0, 1, 4'h0, 32'h0, 0);
        chk("basic.drained", 32'(empty), 32'd1);

        // Fill to full, overflow on the 17th write
        for (int i = 0; i < 16; i++)
            step("fill", 1, 0, 4'(i), 32'hF000_0000 + 32'(i), (i % 5) == 4);
        step("w17", 1, 0, 4'hA, 32'hDEADBEEF, 1);
        chk("ovf.head", rdata, 32'hF000_0000);
        // Full + read + write: write dropped, read accepted
        step("full_rw", 1, 1, 4'hB, 32'hBAD0BAD0, 0);
        for (int i = 0; i < 15; i++) step("drain", 0, 1, 4'h0, 32'h0, 0);

        // Underflow, then clear both sticky flags
        step("under", 0, 1, 4'h0, 32'h0, 0);
        step("clr", 1, 1, 4'h1, 32'h0, 1, 1'b1);
        // Empty + read + write: write accepted, underflow set
        step("empty_rw", 1, 1, 4'h3, 32'h0000_5555, 1);
        step("clr2", 0, 0, 4'h0, 32'h0, 0, 1'b1);

        // Stream at level 5 across multiple wraps
        for (int k = 0; k < 5; k++)
            step("pre5", 1, 0, 4'(k), 32'hA000_0000 + 32'(k), (k % 4) == 3);
        for (int k = 5; k < 45; k++)
            step("wrap", 1, 1, 4'(k), 32'hA000_0000 + 32'(k), (k % 4) == 3);

        // Clock enable low: nothing moves, clr ignored
        for (int i = 0; i < 4; i++) step("hold", 1, 1, 4'hE, 32'h77777777, 1, 1'b0, 1'b0);
        step("hold_clr", 0, 0, 4'h0, 32'h0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step("drain5", 0, 1, 4'h0, 32'h0, 0);

        // Async reset mid-frame at level 7, two frames held
        for (int k = 0; k < 7; k++)
            step("pre7", 1, 0, 4'h5, 32'hC000_0000 + 32'(k), (k == 2) || (k == 5));
        chk("pre_rst.frames", 32'(frames), 32'd2);
        #2 rst_n = 0;
        #1;
        mdl_q.delete(); exp_q.delete();
        m_frames = 0; m_ovf = 0; m_unf = 0;
        check_state("async_rst");
        @(negedge clk);
        #1 rst_n = 1;
        @(posedge clk);
        #1;
        step("post_w1", 1, 0, 4'h9, 32'h12345678, 0);
        step("post_w2", 1, 0, 4'h9, 32'h9ABCDEF0, 1);
        step("post_r1", 0, 1, 4'h0, 32'h0, 0);
        step("post_r2", 0, 1, 4'h0, 32'h0, 0);

        chk("scoreboard.drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
